// File: rtl/serial_paralelo_sync_pkg.sv
// Shared types and constants for the serial-to-parallel word aligner.
// Holds the FSM state encoding, the default alignment symbol and a counter-width helper.
package serial_paralelo_sync_pkg;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam logic [7:0] COM_SYM = 8'hBC;

    // Width needed to count up to max_val without saturation
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/serial_paralelo_sync_des_shift_reg.sv
// Deserialiser shift register: exposes the word that includes the bit being sampled now,
// so the control logic can act on a word at the same edge that completes it.
module des_shift_reg
    import serial_paralelo_sync_pkg::*;
#(
    parameter int                WORD_W = 8,
    parameter logic [WORD_W-1:0] COM    = WORD_W'(COM_SYM)
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] nxt,
    output logic              is_com
);

    // Only WORD_W-1 history bits are needed; the newest bit comes straight from data_in
    logic [WORD_W-2:0] hist_q;

    assign nxt    = {hist_q, data_in};
    assign is_com = (nxt == COM);

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= nxt[WORD_W-2:0];
        end
    end

endmodule

// File: rtl/serial_paralelo_sync.sv
// MSB-first serial-to-parallel receiver with COM-based word alignment, lock
// qualification over consecutive COMs and lock loss after a run of non-COM words.
module serial_paralelo_sync
    import serial_paralelo_sync_pkg::*;
#(
    parameter int                WORD_W     = 8,
    parameter logic [WORD_W-1:0] COM        = WORD_W'(COM_SYM),
    parameter int                LOCK_COUNT = 4,
    parameter int                MAX_GAP    = 16
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic              com_out,
    output logic              active
);

    localparam int BW = cnt_width(WORD_W - 1);
    localparam int CW = cnt_width(LOCK_COUNT);
    localparam int GW = cnt_width(MAX_GAP);

    logic [WORD_W-1:0] nxt;
    logic              is_com;

    des_shift_reg #(
        .WORD_W (WORD_W),
        .COM    (COM)
    ) u_shift (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .nxt     (nxt),
        .is_com  (is_com)
    );

    state_e            state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     com_cnt_q, com_cnt_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              com_q, com_d;
    logic              active_q, active_d;
    logic              boundary;

    assign boundary = (bit_cnt_q == BW'(WORD_W - 1));

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
        com_cnt_d = com_cnt_q;
        gap_cnt_d = gap_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        com_d     = 1'b0;
        active_d  = active_q;

        case (state_q)
            ST_HUNT: begin
                // Bit-by-bit search; a match defines the new word phase
                if (is_com) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CW'(1);
                    com_d     = 1'b1;
                    data_d    = COM;
                    if (LOCK_COUNT == 1) begin
                        state_d   = ST_LOCKED;
                        active_d  = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + CW'(1);
                        com_d     = 1'b1;
                        data_d    = COM;
                        if (com_cnt_q + CW'(1) == CW'(LOCK_COUNT)) begin
                            state_d   = ST_LOCKED;
                            active_d  = 1'b1;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        state_d   = ST_HUNT;
                        com_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    data_d = nxt;
                    if (is_com) begin
                        com_d     = 1'b1;
                        gap_cnt_d = '0;
                    end else begin
                        valid_d   = 1'b1;
                        gap_cnt_d = gap_cnt_q + GW'(1);
                        // The final gap word is still delivered before lock is dropped
                        if (gap_cnt_q + GW'(1) == GW'(MAX_GAP)) begin
                            state_d   = ST_HUNT;
                            active_d  = 1'b0;
                            com_cnt_d = '0;
                        end
                    end
                end
            end
            default: begin
                state_d  = ST_HUNT;
                active_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_HUNT;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            com_q     <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            com_q     <= com_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign com_out   = com_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Self-checking bench: a bit-stream behavioural model is compared against the DUT every
// cycle, and directed scenarios pin the expected word outputs with literal values.
module tb_serial_paralelo_sync;

    localparam int         WORD_W     = 8;
    localparam logic [7:0] COM        = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         MAX_GAP    = 16;

    logic              clk_32f = 1'b0;
    logic              reset   = 1'b1;
    logic              data_in = 1'b0;
    logic [WORD_W-1:0] data_out;
    logic              valid_out;
    logic              com_out;
    logic              active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_paralelo_sync #(
        .WORD_W     (WORD_W),
        .COM        (COM),
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_GAP    (MAX_GAP)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .com_out   (com_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    always @(posedge clk_32f) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Behavioural model: mode 0 searching, 1 qualifying, 2 locked.
    // Word phase is the number of bits received since the last search hit, modulo WORD_W.
    logic [7:0] m_hist   = '0;
    int         m_mode   = 0;
    int         m_since  = 0;
    int         m_coms   = 0;
    int         m_gaps   = 0;
    logic [7:0] m_data   = '0;
    logic       m_valid  = 1'b0;
    logic       m_com    = 1'b0;

    always @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            m_hist = '0; m_mode = 0; m_since = 0; m_coms = 0; m_gaps = 0;
            m_data = '0; m_valid = 1'b0; m_com = 1'b0;
        end else begin
            m_hist  = {m_hist[6:0], data_in};
            m_valid = 1'b0;
            m_com   = 1'b0;
            m_since = m_since + 1;
            if (m_mode == 0) begin
                if (m_hist == COM) begin
                    m_since = 0;
                    m_coms  = 1;
                    m_com   = 1'b1;
                    m_data  = COM;
                    m_mode  = (LOCK_COUNT == 1) ? 2 : 1;
                    m_gaps  = 0;
                end
            end else if (m_since % WORD_W == 0) begin
                if (m_mode == 1) begin
                    if (m_hist == COM) begin
                        m_coms = m_coms + 1;
                        m_com  = 1'b1;
                        m_data = COM;
                        if (m_coms == LOCK_COUNT) begin
                            m_mode = 2;
                            m_gaps = 0;
                        end
                    end else begin
                        m_mode = 0;
                        m_coms = 0;
                    end
                end else begin
                    m_data = m_hist;
                    if (m_hist == COM) begin
                        m_com  = 1'b1;
                        m_gaps = 0;
                    end else begin
                        m_valid = 1'b1;
                        m_gaps  = m_gaps + 1;
                        if (m_gaps == MAX_GAP) begin
                            m_mode = 0;
                            m_coms = 0;
                        end
                    end
                end
            end
        end
    end

    logic [7:0] vq[$];
    int         vt[$];

    always @(negedge clk_32f) begin
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("com_out", 32'(com_out), 32'(m_com));
        chk("active", 32'(active), 32'(m_mode == 2));
        if (valid_out) begin
            vq.push_back(data_out);
            vt.push_back(cyc);
        end
    end

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (2) @(posedge clk_32f);
        #1 reset = 1'b0;
    endtask

    task automatic scenario1(input string tag);
        logic [7:0] exp_w[4];
        exp_w = '{8'hF2, 8'h15, 8'hDD, 8'h45};
        vq.delete();
        vt.delete();
        for (int i = 0; i < 4; i++) begin
            send_word(COM);
            chk({tag, "_com"}, 32'(com_out), 32'd1);
            chk({tag, "_active"}, 32'(active), (i == 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 4; i++) send_word(exp_w[i]);
        for (int i = 0; i < 4; i++) send_word(COM);
        chk({tag, "_nwords"}, 32'(vq.size()), 32'd4);
        if (vq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk({tag, "_word"}, 32'(vq[i]), 32'(exp_w[i]));
            for (int i = 0; i < 3; i++) chk({tag, "_spacing"}, 32'(vt[i+1] - vt[i]), 32'd8);
        end
    endtask

    initial begin
        do_reset();
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_active", 32'(active), 32'd0);

        // Scenario 1
        scenario1("s1");

        // Scenario 2: three junk bits shift the alignment
        do_reset();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        scenario1("s2");

        // Scenario 3: broken qualification then a clean lock
        do_reset();
        for (int i = 0; i < 3; i++) send_word(COM);
        send_word(8'hF2);
        chk("s3_f2_active", 32'(active), 32'd0);
        chk("s3_f2_valid", 32'(valid_out), 32'd0);
        for (int i = 0; i < 4; i++) send_word(COM);
        chk("s3_lock", 32'(active), 32'd1);
        send_word(8'hAA);
        chk("s3_valid", 32'(valid_out), 32'd1);
        chk("s3_data", 32'(data_out), 32'hAA);

        // Scenario 4: lock loss after MAX_GAP non-COM words
        send_word(COM);
        for (int i = 0; i < MAX_GAP; i++) begin
            send_word(8'hAA);
            chk("s4_valid", 32'(valid_out), 32'd1);
            chk("s4_active", 32'(active), (i == MAX_GAP - 1) ? 32'd0 : 32'd1);
        end
        send_word(COM);
        chk("s4_com", 32'(com_out), 32'd1);
        chk("s4_active_after", 32'(active), 32'd0);

        // Scenario 5: straddling COM pattern ignored while locked
        do_reset();
        for (int i = 0; i < 4; i++) send_word(COM);
        send_word(8'h5E);
        chk("s5_valid_5e", 32'(valid_out), 32'd1);
        chk("s5_data_5e", 32'(data_out), 32'h5E);
        send_word(8'h00);
        chk("s5_valid_00", 32'(valid_out), 32'd1);
        chk("s5_data_00", 32'(data_out), 32'h00);
        chk("s5_com", 32'(com_out), 32'd0);
        send_word(COM);
        chk("s5_com_aligned", 32'(com_out), 32'd1);
        chk("s5_active", 32'(active), 32'd1);

        // Scenario 6: reset mid-word
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        reset = 1'b1;
        #1;
        chk("s6_data", 32'(data_out), 32'd0);
        chk("s6_valid", 32'(valid_out), 32'd0);
        chk("s6_com", 32'(com_out), 32'd0);
        chk("s6_active", 32'(active), 32'd0);
        @(posedge clk_32f);
        @(posedge clk_32f);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_word(COM);
            chk("s6_relock", 32'(active), (i == 3) ? 32'd1 : 32'd0);
        end

        // Randomised stream: COM-heavy mix with stray bits and long gap runs
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 10) begin
                send_word(COM);
            end else if (r < 16) begin
                send_word(8'($urandom_range(0, 255)));
            end else if (r < 19) begin
                int nb;
                nb = $urandom_range(1, 5);
                for (int k = 0; k < nb; k++) send_bit(1'($urandom_range(0, 1)));
            end else begin
                for (int k = 0; k < MAX_GAP + 1; k++) send_word(8'($urandom_range(0, 255)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
